// File: rtl/imem_fetch_ctrl_pkg.sv
// rtl/imem_fetch_ctrl_pkg.sv - shared types and constants for the instruction fetch controller
//   fetch_state_e          : FSM state encoding (BOOT, RUN, FAULT)
//   DEF_*                  : default widths for the fetch controller parameters
//   NOP_INST               : RISC-V canonical NOP (addi x0, x0, 0)
package imem_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    localparam int DEF_INST_WIDTH_LENGTH = 32;
    localparam int DEF_PC_WIDTH_LENGTH   = 32;
    localparam int DEF_MAX_MEM_DEPTH_BIT = 18;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/imem_fetch_ctrl_fetch_queue.sv
// rtl/imem_fetch_ctrl_fetch_queue.sv - 2-entry FIFO of {pc, inst} between fetch and decode
//   clk, rst               : clock, asynchronous active-high reset
//   push, push_pc/inst     : enqueue request and entry
//   pop                    : dequeue head (ignored when empty)
//   flush                  : drop all entries; overrides same-cycle push and pop
//   head_valid/pc/inst     : oldest entry
//   count                  : number of valid entries (0..2)
module imem_fetch_ctrl_fetch_queue
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int INST_WIDTH_LENGTH = DEF_INST_WIDTH_LENGTH,
    parameter int PC_WIDTH_LENGTH   = DEF_PC_WIDTH_LENGTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [PC_WIDTH_LENGTH-1:0]   push_pc,
    input  logic [INST_WIDTH_LENGTH-1:0] push_inst,
    input  logic                         pop,
    input  logic                         flush,
    output logic                         head_valid,
    output logic [PC_WIDTH_LENGTH-1:0]   head_pc,
    output logic [INST_WIDTH_LENGTH-1:0] head_inst,
    output logic [1:0]                   count
);

    logic [PC_WIDTH_LENGTH-1:0]   pc_q   [2];
    logic [PC_WIDTH_LENGTH-1:0]   pc_d   [2];
    logic [INST_WIDTH_LENGTH-1:0] inst_q [2];
    logic [INST_WIDTH_LENGTH-1:0] inst_d [2];
    logic                         rd_ptr_q, rd_ptr_d;
    logic                         wr_ptr_q, wr_ptr_d;
    logic [1:0]                   count_q,  count_d;
    logic                         do_push, do_pop;

    always_comb begin
        pc_d     = pc_q;
        inst_d   = inst_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != 2'd0);
        // A push into a full queue is only legal when the head leaves this cycle.
        do_push  = push && ((count_q != 2'd2) || do_pop);

        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                pc_d[wr_ptr_q]   = push_pc;
                inst_d[wr_ptr_q] = push_inst;
                wr_ptr_d         = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + 2'(do_push) - 2'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q[0]   <= '0;
            pc_q[1]   <= '0;
            inst_q[0] <= '0;
            inst_q[1] <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end

    assign head_valid = (count_q != 2'd0);
    assign head_pc    = pc_q[rd_ptr_q];
    assign head_inst  = inst_q[rd_ptr_q];
    assign count      = count_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - PC owner and IMEM fetch sequencer feeding decode through a 2-entry queue
//   clk, rst                    : clock, asynchronous active-high reset
//   fetch_en                    : level enable for issuing fetches
//   redirect_valid, redirect_pc : taken branch/jump target, flushes the queue
//   imem_addr, imem_inst        : combinational word-indexed IMEM read port
//   out_valid/ready/inst/pc     : decode handshake, head of fetch queue
//   fault, fault_pc             : sticky fetch fault and offending byte address
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int                           INST_WIDTH_LENGTH = DEF_INST_WIDTH_LENGTH,
    parameter int                           PC_WIDTH_LENGTH   = DEF_PC_WIDTH_LENGTH,
    parameter int                           MAX_MEM_DEPTH_BIT = DEF_MAX_MEM_DEPTH_BIT,
    parameter logic [PC_WIDTH_LENGTH-1:0]   RESET_PC          = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fetch_en,
    input  logic                         redirect_valid,
    input  logic [PC_WIDTH_LENGTH-1:0]   redirect_pc,
    output logic [31:0]                  imem_addr,
    input  logic [INST_WIDTH_LENGTH-1:0] imem_inst,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [INST_WIDTH_LENGTH-1:0] out_inst,
    output logic [PC_WIDTH_LENGTH-1:0]   out_pc,
    output logic                         fault,
    output logic [PC_WIDTH_LENGTH-1:0]   fault_pc
);

    localparam int IDX_W = MAX_MEM_DEPTH_BIT - 1;

    fetch_state_e               state_q, state_d;
    logic [PC_WIDTH_LENGTH-1:0] pc_q, pc_d;
    logic                       fault_q, fault_d;
    logic [PC_WIDTH_LENGTH-1:0] fault_pc_q, fault_pc_d;

    logic       q_push, q_pop, q_flush, q_valid;
    logic [1:0] q_count;
    logic       pc_oor, target_ok, can_take;

    // Anything above the IMEM index field being set means the address is outside IMEM.
    assign pc_oor    = (pc_q[PC_WIDTH_LENGTH-1:MAX_MEM_DEPTH_BIT+1] != '0);
    assign target_ok = (redirect_pc[1:0] == 2'b00) &&
                       (redirect_pc[PC_WIDTH_LENGTH-1:MAX_MEM_DEPTH_BIT+1] == '0);

    assign imem_addr = {{(32-IDX_W){1'b0}}, pc_q[MAX_MEM_DEPTH_BIT:2]};

    // A redirect flushes the head, so it must not count as accepted by decode.
    assign q_pop    = q_valid && out_ready && !redirect_valid;
    assign can_take = (q_count != 2'd2) || q_pop;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        q_push     = 1'b0;
        q_flush    = 1'b0;

        if (redirect_valid) begin
            q_flush = 1'b1;
            pc_d    = redirect_pc;
            if (!target_ok) begin
                state_d    = FAULT;
                fault_d    = 1'b1;
                fault_pc_d = redirect_pc;
            end else if (state_q == FAULT) begin
                state_d = RUN;
                fault_d = 1'b0;
            end
        end else begin
            case (state_q)
                BOOT: begin
                    if (fetch_en) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (fetch_en && can_take) begin
                        if (pc_oor) begin
                            state_d    = FAULT;
                            fault_d    = 1'b1;
                            fault_pc_d = pc_q;
                        end else begin
                            q_push = 1'b1;
                            pc_d   = pc_q + PC_WIDTH_LENGTH'(4);
                        end
                    end
                end
                FAULT: begin
                end
                default: begin
                    state_d = BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    imem_fetch_ctrl_fetch_queue #(
        .INST_WIDTH_LENGTH (INST_WIDTH_LENGTH),
        .PC_WIDTH_LENGTH   (PC_WIDTH_LENGTH)
    ) u_fetch_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (q_push),
        .push_pc    (pc_q),
        .push_inst  (imem_inst),
        .pop        (q_pop),
        .flush      (q_flush),
        .head_valid (q_valid),
        .head_pc    (out_pc),
        .head_inst  (out_inst),
        .count      (q_count)
    );

    assign out_valid = q_valid;
    assign fault     = fault_q;
    assign fault_pc  = fault_pc_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - directed self-checking bench for imem_fetch_ctrl
module tb_imem_fetch_ctrl;
    import imem_fetch_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        fault;
    logic [31:0] fault_pc;

    int checks = 0;
    int errors = 0;

    imem_fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .fault          (fault),
        .fault_pc       (fault_pc)
    );

    always #5 clk = ~clk;

    // IMEM word k holds 32'h1000_0000 + k.
    assign imem_inst = 32'h1000_0000 + imem_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step();
        step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_fault_pc", fault_pc, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_inst", out_inst, 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);

        rst = 1'b0;
        fetch_en = 1'b1;
        out_ready = 1'b1;
        step();
        chk("boot_valid", 32'(out_valid), 32'd0);

        for (int k = 0; k < 4; k++) begin
            step();
            chk("seq_valid", 32'(out_valid), 32'd1);
            chk("seq_pc", out_pc, 32'(4 * k));
            chk("seq_inst", out_inst, 32'h1000_0000 + 32'(k));
            chk("seq_addr", imem_addr, 32'(k + 1));
        end

        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_pc", out_pc, 32'd12);
            chk("stall_addr", imem_addr, 32'd5);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("drain_pc", out_pc, 32'(16 + 4 * i));
            chk("drain_inst", out_inst, 32'h1000_0000 + 32'(4 + i));
        end

        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        step();
        chk("redir_flush", 32'(out_valid), 32'd0);
        chk("redir_addr", imem_addr, 32'h40);
        redirect_valid = 1'b0;
        step();
        chk("redir_valid", 32'(out_valid), 32'd1);
        chk("redir_pc", out_pc, 32'h100);
        chk("redir_inst", out_inst, 32'h1000_0040);

        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0102;
        step();
        chk("mis_fault", 32'(fault), 32'd1);
        chk("mis_fault_pc", fault_pc, 32'h102);
        chk("mis_valid", 32'(out_valid), 32'd0);
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fault_nopush", 32'(out_valid), 32'd0);
            chk("fault_sticky", 32'(fault), 32'd1);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        step();
        chk("recover_fault", 32'(fault), 32'd0);
        chk("recover_valid", 32'(out_valid), 32'd0);
        redirect_valid = 1'b0;
        step();
        chk("recover_pc", out_pc, 32'h200);
        chk("recover_vld", 32'(out_valid), 32'd1);

        redirect_valid = 1'b1;
        redirect_pc = 32'h0007_FFF0;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("edge_pc", out_pc, 32'h0007_FFF0 + 32'(4 * i));
        end
        out_ready = 1'b0;
        step();
        chk("oor_fault", 32'(fault), 32'd1);
        chk("oor_fault_pc", fault_pc, 32'h0008_0000);
        chk("oor_last_vld", 32'(out_valid), 32'd1);
        chk("oor_last_pc", out_pc, 32'h0007_FFFC);
        out_ready = 1'b1;
        step();
        chk("oor_drained", 32'(out_valid), 32'd0);
        chk("oor_sticky", 32'(fault), 32'd1);

        out_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0007_FFFC;
        step();
        chk("pre_rst_clr", 32'(fault), 32'd0);
        redirect_valid = 1'b0;
        step();
        step();
        chk("pre_rst_fault", 32'(fault), 32'd1);
        chk("pre_rst_vld", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_fault", 32'(fault), 32'd0);
        chk("arst_fault_pc", fault_pc, 32'h0);
        chk("arst_out_pc", out_pc, 32'h0);
        chk("arst_addr", imem_addr, 32'h0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        chk("post_boot_vld", 32'(out_valid), 32'd0);
        step();
        chk("post_vld", 32'(out_valid), 32'd1);
        chk("post_pc", out_pc, 32'h0);
        chk("post_inst", out_inst, 32'h1000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
